y86_execute_stage: RTL
======================

Name: y86_execute_stage

Overview:
Execute (E) stage of the pipelined Y86-64 core. It sits between the D/E pipeline register and the memory stage.
- Selects the ALU operands from the decoded instruction and computes valE with a 64-bit add/sub/and/xor ALU.
- Maintains the condition-code register (ZF/SF/OF) and evaluates Cnd for cmovXX/jXX.
- Owns the E/M pipeline register, with stall and bubble control.
- Drives the combinational e_valE/e_dstE forwarding outputs back to decode.

Parameters:
WIDTH, 64, datapath width (only 64 supported)
RNONE, 4'hF, "no register" destination ID

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
E_stat  in  4  status of instruction in E (AOK=1, HLT=2, ADR=3, INS=4)
E_icode  in  4  instruction code
E_ifun  in  4  function code
E_valA  in  64  operand A from decode
E_valB  in  64  operand B from decode
E_valC  in  64  immediate
E_dstE  in  4  ALU destination register ID
E_dstM  in  4  memory destination register ID
m_stat  in  4  status produced by memory stage this cycle
W_stat  in  4  status held in writeback register
M_stall  in  1  hold E/M register
M_bubble  in  1  load NOP bubble into E/M register
e_valE  out  64  combinational ALU result (forwarding)
e_dstE  out  4  combinational effective dstE (forwarding)
e_Cnd  out  1  combinational condition result
M_stat, M_icode  out  4,4  registered
M_Cnd  out  1  registered
M_valE, M_valA  out  64,64  registered
M_dstE, M_dstM  out  4,4  registered
cc_zf, cc_sf, cc_of  out  1,1,1  condition-code register

Behaviour:
- Reset (async, rst=1): CC={ZF=1,SF=0,OF=0}.
  - E/M register resets to bubble: M_stat=AOK, M_icode=NOP(1), M_Cnd=0, M_valE=0, M_valA=0, M_dstE=M_dstM=RNONE.
  - Reset asserted mid-operation discards the in-flight instruction immediately, with no waiting for a clock edge.
- icode encodings: HALT0 NOP1 RRMOVQ/CMOVXX2 IRMOVQ3 RMMOVQ4 MRMOVQ5 OPQ6 JXX7 CALL8 RET9 PUSHQ A POPQ B.
- aluA selection:
  - RRMOVQ, OPQ → valA.
  - IRMOVQ, RMMOVQ, MRMOVQ → valC.
  - CALL, PUSHQ → -8.
  - RET, POPQ → +8.
  - Otherwise → 0.
- aluB selection:
  - RMMOVQ, MRMOVQ, OPQ, CALL, PUSHQ, RET, POPQ → valB.
  - Otherwise → 0.
- alufun: ifun when icode=OPQ, else ADD.
- ALU operations: ADD0: B+A; SUB1: B−A (two's complement, B + ~A + 1); AND2; XOR3.
  - OPQ with ifun>3: valE=0 and CC not updated.
- Flags, all modulo 2^64, carry-out ignored:
  - ZF = (valE==0).
  - SF = valE[63].
  - OF, add: A[63]==B[63] && valE[63]!=B[63].
  - OF, sub: A[63]!=B[63] && valE[63]!=B[63].
  - OF, and/xor: 0.
- set_cc = (E_icode==OPQ) && valid ifun && m_stat ∉ {HLT,ADR,INS} && W_stat ∉ {HLT,ADR,INS}.
  - When set, CC loads on the next rising edge; otherwise CC holds.
- e_Cnd uses current CC contents, not this cycle's update. Evaluated per ifun:
  - 0 always = 1.
  - 1 le = (SF^OF)|ZF.
  - 2 l = SF^OF.
  - 3 e = ZF.
  - 4 ne = ~ZF.
  - 5 ge = ~(SF^OF).
  - 6 g = ~(SF^OF)&~ZF.
  - ifun>6 = 0.
- e_dstE = RNONE when E_icode==RRMOVQ && !e_Cnd; otherwise E_dstE.
- E/M register update on a rising edge, highest priority first:
  - rst: reset values.
  - M_stall: hold all M_* values.
  - M_bubble: load reset (bubble) values.
  - Otherwise: M_stat←E_stat, M_icode←E_icode, M_Cnd←e_Cnd, M_valE←e_valE, M_valA←E_valA, M_dstE←e_dstE, M_dstM←E_dstM.
- M_stall and M_bubble asserted together: stall wins. CC update is unaffected by either.
- Latency: e_* outputs are combinational (0 cycles); M_* outputs and CC update one cycle after inputs.

Decomposition:
- Shared package y86_pkg: icode, ifun/ALU-op and condition encodings, stat codes (AOK/HLT/ADR/INS), RNONE, and the bubble value for pipeline registers.
- Sub-module y86_alu: combinational. Inputs aluA, aluB, alufun. Outputs valE, zf, sf, of. Add/sub are built on the team's 64-bit ripple adder cell.
- Operand selection, CC register, condition evaluation and E/M register live in y86_execute_stage.

Test Plan:
- Reset: rst pulse asynchronous to clk → CC=1/0/0, M_icode=1, M_dstE=M_dstM=4'hF, M_valE=0, without waiting for an edge.
- OPQ addq, valA=1, valB=0x7FFF_FFFF_FFFF_FFFF → e_valE=0x8000_0000_0000_0000 same cycle; after edge ZF=0, SF=1, OF=1, M_valE matches.
- OPQ subq, valA=valB=5 → valE=0, ZF=1. Next cycle cmovne (icode2, ifun4, dstE=3) → e_Cnd=0, e_dstE=F, M_dstE=F, M_Cnd=0.
- Memory exception: OPQ xorq valA=valB=0xFF with m_stat=ADR(3) → e_valE=0 but CC unchanged. Repeat with W_stat=HLT → CC unchanged.
- Stack pointer arithmetic:
  - pushq valB=0x100 → M_valE=0xF8.
  - popq valB=0x100 → 0x108.
  - call valB=0x8 → 0x0.
  - mrmovq valC=0x10, valB=0x20 → 0x30.
- Pipeline control:
  - M_stall=1 for 2 cycles with changing E inputs → M_* held.
  - M_stall=M_bubble=1 → held.
  - M_bubble=1 alone → M_icode=NOP, M_dstE=F.
  - jle with ZF=1 → M_Cnd=1.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 pipeline: instruction codes, ALU
// function codes, branch/move condition codes, status codes, the
// "no register" ID and the bubble value loaded into pipeline registers.
package y86_pkg;

    localparam int         WIDTH = 64;
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_XOR = 4'h3
    } alu_fun_e;

    typedef enum logic [3:0] {
        C_ALWAYS = 4'h0,
        C_LE     = 4'h1,
        C_L      = 4'h2,
        C_E      = 4'h3,
        C_NE     = 4'h4,
        C_GE     = 4'h5,
        C_G      = 4'h6
    } cond_e;

    typedef enum logic [3:0] {
        S_AOK = 4'h1,
        S_HLT = 4'h2,
        S_ADR = 4'h3,
        S_INS = 4'h4
    } stat_e;

    typedef struct packed {
        logic [3:0]       stat;
        logic [3:0]       icode;
        logic             cnd;
        logic [WIDTH-1:0] val_e;
        logic [WIDTH-1:0] val_a;
        logic [3:0]       dst_e;
        logic [3:0]       dst_m;
    } em_reg_t;

    localparam em_reg_t EM_BUBBLE = '{
        stat:  S_AOK,
        icode: I_NOP,
        cnd:   1'b0,
        val_e: '0,
        val_a: '0,
        dst_e: RNONE,
        dst_m: RNONE
    };

    // An instruction that has faulted or halted further down the pipe must
    // not let younger instructions modify architectural condition codes.
    function automatic logic stat_is_exception(input logic [3:0] stat);
        return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
    endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational 64-bit Y86 ALU.
//   alu_a, alu_b : operands (result is B op A)
//   alufun       : ADD/SUB/AND/XOR; other codes give val_e=0, fun_valid=0
//   val_e        : result
//   zf, sf, of   : flags for the condition-code register
//   fun_valid    : alufun is a defined operation
module y86_alu
    import y86_pkg::*;
(
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [3:0]       alufun,
    output logic [WIDTH-1:0] val_e,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             fun_valid
);

    logic             is_sub;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             carry;

    assign is_sub = (alufun == ALU_SUB);
    assign addend = is_sub ? ~alu_a : alu_a;

    // Ripple-carry adder; subtraction is B + ~A + 1 with the +1 as carry-in.
    always_comb begin
        sum   = '0;
        carry = is_sub;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = alu_b[i] ^ addend[i] ^ carry;
            carry  = (alu_b[i] & addend[i]) | (carry & (alu_b[i] ^ addend[i]));
        end
    end

    always_comb begin
        val_e     = '0;
        of        = 1'b0;
        fun_valid = 1'b1;
        case (alufun)
            ALU_ADD: begin
                val_e = sum;
                of    = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                        (sum[WIDTH-1] != alu_b[WIDTH-1]);
            end
            ALU_SUB: begin
                val_e = sum;
                of    = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                        (sum[WIDTH-1] != alu_b[WIDTH-1]);
            end
            ALU_AND: val_e = alu_b & alu_a;
            ALU_XOR: val_e = alu_b ^ alu_a;
            default: fun_valid = 1'b0;
        endcase
    end

    assign zf = (val_e == '0);
    assign sf = val_e[WIDTH-1];

endmodule

// File: rtl/y86_execute_stage.sv
// Execute stage of the pipelined Y86-64 core.
//   E_*              : decoded instruction from the D/E register
//   m_stat, W_stat   : status of older instructions (gate CC updates)
//   M_stall/M_bubble : E/M register control (stall has priority)
//   e_valE/e_dstE    : combinational forwarding back to decode
//   e_Cnd            : condition result from the current CC contents
//   M_*              : E/M pipeline register
//   cc_zf/sf/of      : condition-code register
module y86_execute_stage
    import y86_pkg::*;
#(
    parameter int WIDTH_P = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         E_stat,
    input  logic [3:0]         E_icode,
    input  logic [3:0]         E_ifun,
    input  logic [WIDTH_P-1:0] E_valA,
    input  logic [WIDTH_P-1:0] E_valB,
    input  logic [WIDTH_P-1:0] E_valC,
    input  logic [3:0]         E_dstE,
    input  logic [3:0]         E_dstM,
    input  logic [3:0]         m_stat,
    input  logic [3:0]         W_stat,
    input  logic               M_stall,
    input  logic               M_bubble,
    output logic [WIDTH_P-1:0] e_valE,
    output logic [3:0]         e_dstE,
    output logic               e_Cnd,
    output logic [3:0]         M_stat,
    output logic [3:0]         M_icode,
    output logic               M_Cnd,
    output logic [WIDTH_P-1:0] M_valE,
    output logic [WIDTH_P-1:0] M_valA,
    output logic [3:0]         M_dstE,
    output logic [3:0]         M_dstM,
    output logic               cc_zf,
    output logic               cc_sf,
    output logic               cc_of
);

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alufun;
    logic [WIDTH-1:0] alu_val_e;
    logic             alu_zf;
    logic             alu_sf;
    logic             alu_of;
    logic             alu_fun_valid;
    logic             set_cc;

    logic    cc_zf_q, cc_zf_d;
    logic    cc_sf_q, cc_sf_d;
    logic    cc_of_q, cc_of_d;
    em_reg_t em_q, em_d;

    always_comb begin
        alu_a = '0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:             alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
            I_CALL, I_PUSHQ:             alu_a = -64'sd8;
            I_RET, I_POPQ:               alu_a = 64'd8;
            default:                     alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
            I_PUSHQ, I_RET, I_POPQ:      alu_b = E_valB;
            default:                     alu_b = '0;
        endcase
    end

    assign alufun = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;

    y86_alu u_alu (
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alufun    (alufun),
        .val_e     (alu_val_e),
        .zf        (alu_zf),
        .sf        (alu_sf),
        .of        (alu_of),
        .fun_valid (alu_fun_valid)
    );

    assign set_cc = (E_icode == I_OPQ) && alu_fun_valid &&
                    !stat_is_exception(m_stat) && !stat_is_exception(W_stat);

    // Condition uses the CC as it stands; an OPq in E this cycle only
    // affects the instruction behind it.
    always_comb begin
        e_Cnd = 1'b0;
        case (E_ifun)
            C_ALWAYS: e_Cnd = 1'b1;
            C_LE:     e_Cnd = (cc_sf_q ^ cc_of_q) | cc_zf_q;
            C_L:      e_Cnd = cc_sf_q ^ cc_of_q;
            C_E:      e_Cnd = cc_zf_q;
            C_NE:     e_Cnd = ~cc_zf_q;
            C_GE:     e_Cnd = ~(cc_sf_q ^ cc_of_q);
            C_G:      e_Cnd = ~(cc_sf_q ^ cc_of_q) & ~cc_zf_q;
            default:  e_Cnd = 1'b0;
        endcase
    end

    assign e_valE = alu_val_e;
    // A cmov whose condition fails must not write, and forwarding must see that.
    assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? RNONE : E_dstE;

    always_comb begin
        cc_zf_d = cc_zf_q;
        cc_sf_d = cc_sf_q;
        cc_of_d = cc_of_q;
        if (set_cc) begin
            cc_zf_d = alu_zf;
            cc_sf_d = alu_sf;
            cc_of_d = alu_of;
        end
    end

    always_comb begin
        em_d = em_q;
        if (M_stall) begin
            em_d = em_q;
        end else if (M_bubble) begin
            em_d = EM_BUBBLE;
        end else begin
            em_d.stat  = E_stat;
            em_d.icode = E_icode;
            em_d.cnd   = e_Cnd;
            em_d.val_e = e_valE;
            em_d.val_a = E_valA;
            em_d.dst_e = e_dstE;
            em_d.dst_m = E_dstM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_zf_q <= 1'b1;
            cc_sf_q <= 1'b0;
            cc_of_q <= 1'b0;
            em_q    <= EM_BUBBLE;
        end else begin
            cc_zf_q <= cc_zf_d;
            cc_sf_q <= cc_sf_d;
            cc_of_q <= cc_of_d;
            em_q    <= em_d;
        end
    end

    assign cc_zf   = cc_zf_q;
    assign cc_sf   = cc_sf_q;
    assign cc_of   = cc_of_q;
    assign M_stat  = em_q.stat;
    assign M_icode = em_q.icode;
    assign M_Cnd   = em_q.cnd;
    assign M_valE  = em_q.val_e;
    assign M_valA  = em_q.val_a;
    assign M_dstE  = em_q.dst_e;
    assign M_dstM  = em_q.dst_m;

endmodule
